ps2_rx_fifo: RTL
================

// Module: ps2_rx_fifo
// PURPOSE
// - PS/2 device-to-host receiver with an on-chip scancode FIFO and a small register interface.
// - Successor to the single-keycode PS/2 peripheral:
//   - adds a parametrised FIFO depth, clock glitch filtering, parity/framing checks and a frame timeout;
//   - replaces the one-cycle irq pulse with a maskable level irq, plus overflow and error status.
// - Sits on the QuasiSoC peripheral bus (a/d/we/spo) next to uart/timer; irq goes to the interrupt controller.
// PARAMETERS
// - DEPTH       16     FIFO entries; power of 2, 2..128
// - FILTER      4      consecutive equal samples needed before the filtered kclk may change (>=2)
// - TIMEOUT_CYC 50000  max clk cycles between filtered kclk falling edges inside a frame
// PORTS
// - clk    in   1   system clock, single clock domain
// - rst    in   1   synchronous, active-low reset (rst==0 at a clk edge resets)
// - a      in   3   register word address
// - d      in   32  write data
// - we     in   1   write strobe, one clk per access
// - spo    out  32  combinational read data for address a
// - irq    out  1   level interrupt
// - kclk   in   1   PS/2 clock pin, asynchronous
// - kdata  in   1   PS/2 data pin, asynchronous
// BEHAVIOUR
// - Input conditioning:
//   - kclk and kdata each go through a 2-FF synchroniser.
//   - kclk_f takes the synchronised value only after FILTER consecutive equal samples.
//   - A bit is sampled on the kclk_f 1->0 transition (fall): kdata_sync at that cycle.
// - Frame FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
//   - IDLE: on fall with kdata==0 (start bit) go to DATA, bitcnt=0; a fall with kdata==1 is ignored.
//   - DATA: shift bits in LSB first; after the 8th bit go to PARITY.
//   - PARITY: record the parity bit; go to STOP.
//   - STOP: on fall, the frame is good iff odd parity holds over data+parity and stop==1.
//     Good frame: push the byte. Bad frame: set perr, discard. Either way return to IDLE.
//   - Timeout: a counter is cleared on every fall. In any state other than IDLE, reaching
//     TIMEOUT_CYC returns the FSM to IDLE, discards the partial byte and sets no flag.
// - Latency: a pushed byte is visible in DATA (valid=1) on the cycle after the stop-bit fall.
// - FIFO: circular buffer with wr_ptr, rd_ptr and count (width $clog2(DEPTH)+1).
//   - Push when count==DEPTH: byte dropped, ovf set, FIFO contents unchanged.
//   - Push and pop in the same cycle:
//     - both take effect and count is unchanged;
//     - when full, the push is accepted (no ovf);
//     - when empty, the pop is ignored and the push happens.
//   - Flush in the same cycle as a push: flush wins and the byte is dropped (no ovf).
// - Registers (word address a):
//   - 0 DATA  R: {valid[31], 7'b0, 8'(count)[23:16], 8'b0, head_byte[7:0]}; head_byte=0 when empty.
//             W (any d): pop one entry if non-empty; a write when empty has no effect.
//   - 1 STAT  R: {29'b0, perr[2], ovf[1], nonempty[0]}.
//             W: W1C on bits 2:1; bit 0 is read-only.
//   - 2 CTRL  R: {31'b0, irq_en[0]}.
//             W: d[0] sets irq_en; d[1]=1 flushes the FIFO this cycle (self-clearing, reads 0).
//   - 3..7    read 0, writes ignored.
// - A flag set and a W1C clear of the same flag in one cycle: set wins.
// - irq = irq_en & (count!=0 | ovf | perr), driven from registers (no combinational path from a/d/we).
// - Reset values: irq=0, irq_en=0, count=0, pointers=0, ovf=0, perr=0, FSM=IDLE, filter and
//   sync chains=1 (bus idle high), timeout counter=0.
// - Reset asserted mid-frame aborts the frame; no partial byte is ever pushed.
// - spo is purely combinational on a and register state.
// STRUCTURE
// - ps2_pkg: register addresses (REG_DATA/REG_STAT/REG_CTRL), STAT/CTRL bit indices, FSM
//   state encoding (2 bits), PS2 frame constants.
// - Sub-module ps2_frame_rx:
//   - inputs: clk, rst, kclk, kdata;
//   - outputs: byte_valid (1-cycle), byte_data[7:0], frame_err (1-cycle);
//   - contains the synchroniser, filter, FSM and timeout.
// - The top holds the FIFO storage (reg array), status/ctrl registers and the bus decode.
// TESTING (bench PS/2 bit period ~60us modelled as 2000 clk per half-period unless stated; FILTER=4)
// 1. irq_en=1; send 0x1C with correct parity -> 1 cycle after stop fall: DATA reads 0x0001_001C | bit31,
//    irq=1. Write a=0 -> DATA reads 0x0000_0000, irq=0.
// 2. Send 0x1C with parity bit inverted -> count stays 0, STAT=0x4, irq=1.
//    Write STAT=0x4 -> STAT=0x0, irq=0.
// 3. Send 17 bytes 0x01..0x11 with no pops (DEPTH=16) -> count=16, STAT=0x3, head=0x01.
//    16 pops return 0x01..0x10; 0x11 never appears.
// 4. With FIFO full, issue a pop write on the same cycle the stop-bit fall of byte 0x22 is processed
//    -> count stays 16, ovf not set, 0x22 is the last byte popped.
// 5. Glitch and timeout:
//    - a 2-cycle low pulse on kclk -> no bit counted;
//    - start + 3 data bits then idle TIMEOUT_CYC+10 cycles, then a full frame 0xF0 -> FIFO holds
//      only 0xF0, perr=0.
// 6. Reset and flush:
//    - assert rst=0 for 1 cycle after 5 data bits, then send 0x5A -> FIFO holds only 0x5A, all
//      flags 0, irq_en=0;
//    - CTRL write d=0x2 with 3 entries queued -> count=0 next cycle.

Source files
------------

// File: rtl/ps2_rx_fifo_pkg.sv
// Shared constants for the PS/2 receiver: register map, status/control bit
// positions, frame FSM encoding and PS/2 frame layout.
package ps2_rx_fifo_pkg;

  // Register word addresses on the peripheral bus
  localparam logic [2:0] REG_DATA = 3'd0;
  localparam logic [2:0] REG_STAT = 3'd1;
  localparam logic [2:0] REG_CTRL = 3'd2;

  // STAT register bit positions
  localparam int STAT_NONEMPTY = 0;
  localparam int STAT_OVF      = 1;
  localparam int STAT_PERR     = 2;

  // CTRL register bit positions
  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_FLUSH  = 1;

  // Frame FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // PS/2 frame layout: start, 8 data bits LSB first, odd parity, stop
  localparam int FRAME_DATA_BITS = 8;

  // Odd parity holds when data plus parity bit carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// QuasiSoC peripheral bus: word address, write data, write strobe and
// combinational read data.
interface ps2_rx_fifo_if;
  logic [2:0]  a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo;

  modport master (output a, output d, output we, input spo);
  modport slave  (input a, input d, input we, output spo);
endinterface

// File: rtl/ps2_rx_fifo_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, kclk glitch filter, frame FSM with
// parity/stop checks and an inter-edge timeout. Emits one-cycle strobes for a
// good byte or a bad frame.
module ps2_frame_rx
  import ps2_rx_fifo_pkg::*;
#(
  parameter int FILTER      = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kclk,
  input  logic       kdata,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int FCW = $clog2(FILTER) + 1;
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  logic           kclk_s1_q, kclk_s2_q, kdata_s1_q, kdata_s2_q;
  logic           kclk_f_q, kclk_f_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic           filt_flip, fall;

  logic [1:0]     state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TCW-1:0] tmo_q, tmo_d;

  // Two-flop synchronisers for both asynchronous pins; the bus idles high
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      kclk_s1_q  <= 1'b1;
      kclk_s2_q  <= 1'b1;
      kdata_s1_q <= 1'b1;
      kdata_s2_q <= 1'b1;
    end else begin
      kclk_s1_q  <= kclk;
      kclk_s2_q  <= kclk_s1_q;
      kdata_s1_q <= kdata;
      kdata_s2_q <= kdata_s2_q == kdata_s1_q ? kdata_s2_q : kdata_s1_q;
    end
  end

  // Glitch filter: the filtered clock follows only after FILTER consecutive differing samples
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    filt_flip  = 1'b0;
    filt_cnt_d = '0;
    kclk_f_d   = kclk_f_q;
    if (kclk_s2_q != kclk_f_q) begin
      if (filt_cnt_q == FCW'(FILTER - 1)) begin
        filt_flip = 1'b1;
        kclk_f_d  = kclk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FCW'(1);
      end
    end
  end

  // A flip away from a high filtered clock is the sampling edge
  assign fall = filt_flip & kclk_f_q;

  // Filter state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      kclk_f_q   <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      kclk_f_q   <= kclk_f_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // Frame FSM, bit shifter and timeout; a stalled frame is dropped silently
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    tmo_d      = (fall || state_q == ST_IDLE) ? '0 : tmo_q + TCW'(1);

    case (state_q)
      ST_IDLE: begin
        if (fall && !kdata_s2_q) begin
          state_d  = ST_DATA;
          bitcnt_d = '0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d  = {kdata_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'(FRAME_DATA_BITS - 1)) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_d   = kdata_s2_q;
          state_d = ST_STOP;
        end
      end
      default: begin
        if (fall) begin
          if (odd_parity_ok(shift_q, par_q) && kdata_s2_q) byte_valid = 1'b1;
          else                                              frame_err  = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase

    if (!fall && state_q != ST_IDLE && tmo_q >= TCW'(TIMEOUT_CYC)) begin
      state_d = ST_IDLE;
    end
  end

  assign byte_data = shift_q;

  // Frame FSM registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver peripheral: frame receiver feeding a circular scancode FIFO,
// STAT/CTRL registers, bus decode and a maskable level interrupt.
module ps2_rx_fifo
  import ps2_rx_fifo_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int FILTER      = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic         clk,
  input  logic         rst,
  ps2_rx_fifo_if.slave bus,
  output logic         irq,
  input  logic         kclk,
  input  logic         kdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          byte_valid, frame_err;
  logic [7:0]    byte_data;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, perr_q, perr_d, irq_en_q, irq_en_d;

  logic          wr_data, wr_stat, wr_ctrl, flush;
  logic          empty, full, do_pop, do_push, ovf_set;
  logic [7:0]    head_byte;

  ps2_frame_rx #(
    .FILTER      (FILTER),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_rx (
    .clk        (clk),
    .rst        (rst),
    .kclk       (kclk),
    .kdata      (kdata),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  // Bus write decode and FIFO push/pop arbitration; flush overrides everything
  always_comb begin
    wr_data = bus.we && (bus.a == REG_DATA);
    wr_stat = bus.we && (bus.a == REG_STAT);
    wr_ctrl = bus.we && (bus.a == REG_CTRL);
    flush   = wr_ctrl && bus.d[CTRL_FLUSH];
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    do_pop  = wr_data && !empty && !flush;
    do_push = byte_valid && (!full || do_pop) && !flush;
    ovf_set = byte_valid && full && !do_pop && !flush;
  end

  // Next-state for pointers, occupancy and flags; a flag set beats its W1C clear
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    ovf_d    = ovf_set   | (ovf_q  & ~(wr_stat & bus.d[STAT_OVF]));
    perr_d   = frame_err | (perr_q & ~(wr_stat & bus.d[STAT_PERR]));
    irq_en_d = wr_ctrl ? bus.d[CTRL_IRQ_EN] : irq_en_q;
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
      irq_en_q <= irq_en_d;
    end
  end

  // FIFO storage write port
  // NOTE: storage has no reset; entries are only visible through count, which is reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= byte_data;
  end

  // Combinational read mux from address and register state only
  always_comb begin
    head_byte = empty ? 8'h00 : mem_q[rd_ptr_q];
    case (bus.a)
      REG_DATA: bus.spo = {~empty, 7'b0, 8'(count_q), 8'b0, head_byte};
      REG_STAT: bus.spo = {29'b0, perr_q, ovf_q, ~empty};
      REG_CTRL: bus.spo = {31'b0, irq_en_q};
      default:  bus.spo = 32'h0;
    endcase
  end

  assign irq = irq_en_q & (~empty | ovf_q | perr_q);

endmodule
